// File: rtl/fibonacci_checker.sv
// fibonacci_checker: stream monitor for a Fibonacci term generator.
// It checks each accepted term against the two seeds and then against the
// running sum of the previous two received terms. It counts accepted and
// matching terms and latches a record of the first mismatch.
module fibonacci_checker #(
    parameter int unsigned          WIDTH       = 32,
    parameter int unsigned          CNT_W       = 16,
    parameter logic [WIDTH-1:0]     SEED0       = '0,
    parameter logic [WIDTH-1:0]     SEED1       = WIDTH'(1),
    parameter bit                   HALT_ON_ERR = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                in_valid,
    input  logic [WIDTH-1:0]    in_data,
    output logic                in_ready,
    output logic [CNT_W-1:0]    term_count,
    output logic [CNT_W-1:0]    match_count,
    output logic                error,
    output logic [CNT_W-1:0]    err_index,
    output logic [WIDTH-1:0]    err_expected,
    output logic [WIDTH-1:0]    err_actual,
    output logic                wrapped
);

    typedef enum logic [1:0] {
        S_FIRST  = 2'd0,
        S_SECOND = 2'd1,
        S_RUN    = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state;
    logic [WIDTH-1:0]   prev1;
    logic [WIDTH-1:0]   prev2;

    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   expected;
    logic               accept;
    logic               match;
    logic               term_sat;
    logic               match_sat;

    // Ready depends only on the state, so there is no path from in_valid.
    assign in_ready = (state != S_HALT);
    assign accept   = in_valid && in_ready;

    // Carry-out of this sum is what flags a wrapped term.
    assign sum = {1'b0, prev1} + {1'b0, prev2};

    // Value the current term must equal, selected by the stream position.
    always_comb begin
        expected = '0;
        case (state)
            S_FIRST:  expected = SEED0;
            S_SECOND: expected = SEED1;
            S_RUN:    expected = sum[WIDTH-1:0];
            default:  expected = '0;
        endcase
    end

    assign match     = (in_data == expected);
    assign term_sat  = (term_count == CNT_MAX);
    assign match_sat = (match_count == CNT_MAX);

    // Stream position FSM, term history, counters and first-error record.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_FIRST;
            prev1        <= '0;
            prev2        <= '0;
            term_count   <= '0;
            match_count  <= '0;
            error        <= 1'b0;
            err_index    <= '0;
            err_expected <= '0;
            err_actual   <= '0;
            wrapped      <= 1'b0;
        end else if (clear) begin
            state        <= S_FIRST;
            prev1        <= '0;
            prev2        <= '0;
            term_count   <= '0;
            match_count  <= '0;
            error        <= 1'b0;
            err_index    <= '0;
            err_expected <= '0;
            err_actual   <= '0;
            wrapped      <= 1'b0;
        end else if (accept) begin
            // History tracks received values so one bad term cannot
            // corrupt the rest of the stream.
            prev2 <= prev1;
            prev1 <= in_data;

            if (!term_sat) begin
                term_count <= term_count + CNT_W'(1);
            end
            if (match && !match_sat) begin
                match_count <= match_count + CNT_W'(1);
            end

            if ((state == S_RUN) && sum[WIDTH]) begin
                wrapped <= 1'b1;
            end

            // Only the first mismatch is recorded; later ones leave it alone.
            if (!match && !error) begin
                error        <= 1'b1;
                err_index    <= term_count;
                err_expected <= expected;
                err_actual   <= in_data;
            end

            if (!match && !error && HALT_ON_ERR) begin
                state <= S_HALT;
            end else begin
                case (state)
                    S_FIRST:  state <= S_SECOND;
                    S_SECOND: state <= S_RUN;
                    S_RUN:    state <= S_RUN;
                    default:  state <= state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fibonacci_checker.sv
// Directed testbench for fibonacci_checker: a vector table for the basic
// stream, clear and halt behaviour, plus hand-written sequences for the
// non-halting mode, wrap, counter saturation and asynchronous reset.
module tb_fibonacci_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic [31:0] in_data;

    // Instance with HALT_ON_ERR=1 (default parameters).
    logic        h_ready, h_error, h_wrapped;
    logic [15:0] h_term, h_match, h_eidx;
    logic [31:0] h_eexp, h_eact;

    // Instance with HALT_ON_ERR=0.
    logic        n_ready, n_error, n_wrapped;
    logic [15:0] n_term, n_match, n_eidx;
    logic [31:0] n_eexp, n_eact;

    // Instance with a narrow counter, used for saturation.
    logic        s_ready, s_error, s_wrapped;
    logic [2:0]  s_term, s_match, s_eidx;
    logic [31:0] s_eexp, s_eact;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fibonacci_checker dut_h (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_ready(h_ready), .term_count(h_term), .match_count(h_match), .error(h_error),
        .err_index(h_eidx), .err_expected(h_eexp), .err_actual(h_eact), .wrapped(h_wrapped)
    );

    fibonacci_checker #(.HALT_ON_ERR(1'b0)) dut_n (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_ready(n_ready), .term_count(n_term), .match_count(n_match), .error(n_error),
        .err_index(n_eidx), .err_expected(n_eexp), .err_actual(n_eact), .wrapped(n_wrapped)
    );

    fibonacci_checker #(.CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_ready(s_ready), .term_count(s_term), .match_count(s_match), .error(s_error),
        .err_index(s_eidx), .err_expected(s_eexp), .err_actual(s_eact), .wrapped(s_wrapped)
    );

    typedef struct {
        logic        clr;
        logic        vld;
        logic [31:0] data;
        logic [15:0] tc;
        logic [15:0] mc;
        logic        err;
        logic        rdy;
        logic        wrp;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic clr, input logic vld, input logic [31:0] data,
                                input logic [15:0] tc, input logic [15:0] mc,
                                input logic err, input logic rdy, input logic wrp);
        vec_t v;
        v.clr = clr; v.vld = vld; v.data = data; v.tc = tc; v.mc = mc;
        v.err = err; v.rdy = rdy; v.wrp = wrp;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic tick(input logic clr, input logic vld, input logic [31:0] data);
        clear    = clr;
        in_valid = vld;
        in_data  = data;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic check_h_reset(input string tag);
        check({tag, " ready"},   64'(h_ready),   64'(1));
        check({tag, " term"},    64'(h_term),    64'(0));
        check({tag, " match"},   64'(h_match),   64'(0));
        check({tag, " error"},   64'(h_error),   64'(0));
        check({tag, " eidx"},    64'(h_eidx),    64'(0));
        check({tag, " eexp"},    64'(h_eexp),    64'(0));
        check({tag, " eact"},    64'(h_eact),    64'(0));
        check({tag, " wrapped"}, 64'(h_wrapped), 64'(0));
    endtask

    initial begin
        logic [31:0] fa, fb, fn;

        // Stream 0..13, clear with valid, idle gaps, then a bad term 4 at index 4.
        vecs[0]  = mk(1'b0, 1'b1, 32'd0,  16'd1, 16'd1, 1'b0, 1'b1, 1'b0);
        vecs[1]  = mk(1'b0, 1'b1, 32'd1,  16'd2, 16'd2, 1'b0, 1'b1, 1'b0);
        vecs[2]  = mk(1'b0, 1'b1, 32'd1,  16'd3, 16'd3, 1'b0, 1'b1, 1'b0);
        vecs[3]  = mk(1'b0, 1'b1, 32'd2,  16'd4, 16'd4, 1'b0, 1'b1, 1'b0);
        vecs[4]  = mk(1'b0, 1'b1, 32'd3,  16'd5, 16'd5, 1'b0, 1'b1, 1'b0);
        vecs[5]  = mk(1'b0, 1'b1, 32'd5,  16'd6, 16'd6, 1'b0, 1'b1, 1'b0);
        vecs[6]  = mk(1'b0, 1'b1, 32'd8,  16'd7, 16'd7, 1'b0, 1'b1, 1'b0);
        vecs[7]  = mk(1'b0, 1'b1, 32'd13, 16'd8, 16'd8, 1'b0, 1'b1, 1'b0);
        vecs[8]  = mk(1'b1, 1'b1, 32'd99, 16'd0, 16'd0, 1'b0, 1'b1, 1'b0);
        vecs[9]  = mk(1'b0, 1'b1, 32'd0,  16'd1, 16'd1, 1'b0, 1'b1, 1'b0);
        vecs[10] = mk(1'b0, 1'b0, 32'd77, 16'd1, 16'd1, 1'b0, 1'b1, 1'b0);
        vecs[11] = mk(1'b0, 1'b1, 32'd1,  16'd2, 16'd2, 1'b0, 1'b1, 1'b0);
        vecs[12] = mk(1'b0, 1'b0, 32'd5,  16'd2, 16'd2, 1'b0, 1'b1, 1'b0);
        vecs[13] = mk(1'b0, 1'b1, 32'd1,  16'd3, 16'd3, 1'b0, 1'b1, 1'b0);
        vecs[14] = mk(1'b0, 1'b1, 32'd2,  16'd4, 16'd4, 1'b0, 1'b1, 1'b0);
        vecs[15] = mk(1'b0, 1'b1, 32'd4,  16'd5, 16'd4, 1'b1, 1'b0, 1'b0);
        vecs[16] = mk(1'b0, 1'b1, 32'd3,  16'd5, 16'd4, 1'b1, 1'b0, 1'b0);

        rst      = 1'b1;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        #12;
        check_h_reset("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table-driven stream against the halting instance.
        for (int i = 0; i < NVEC; i++) begin
            tick(vecs[i].clr, vecs[i].vld, vecs[i].data);
            check($sformatf("v%0d term", i),    64'(h_term),    64'(vecs[i].tc));
            check($sformatf("v%0d match", i),   64'(h_match),   64'(vecs[i].mc));
            check($sformatf("v%0d error", i),   64'(h_error),   64'(vecs[i].err));
            check($sformatf("v%0d ready", i),   64'(h_ready),   64'(vecs[i].rdy));
            check($sformatf("v%0d wrapped", i), 64'(h_wrapped), 64'(vecs[i].wrp));
        end
        check("halt eidx", 64'(h_eidx), 64'(4));
        check("halt eexp", 64'(h_eexp), 64'(3));
        check("halt eact", 64'(h_eact), 64'(4));

        // Non-halting mode: checking resumes on the received history.
        tick(1'b1, 1'b0, 32'd0);
        check("clear error", 64'(h_error), 64'(0));
        check("clear ready", 64'(h_ready), 64'(1));
        tick(1'b0, 1'b1, 32'd0);
        tick(1'b0, 1'b1, 32'd1);
        tick(1'b0, 1'b1, 32'd1);
        tick(1'b0, 1'b1, 32'd2);
        tick(1'b0, 1'b1, 32'd4);
        tick(1'b0, 1'b1, 32'd6);
        tick(1'b0, 1'b1, 32'd10);
        check("nohalt term",  64'(n_term),  64'(7));
        check("nohalt match", 64'(n_match), 64'(6));
        check("nohalt error", 64'(n_error), 64'(1));
        check("nohalt eidx",  64'(n_eidx),  64'(4));
        check("nohalt eexp",  64'(n_eexp),  64'(3));
        check("nohalt eact",  64'(n_eact),  64'(4));
        check("nohalt ready", 64'(n_ready), 64'(1));
        check("halt term",    64'(h_term),  64'(5));

        // Wrap: F0..F47, then the modulo-2^32 sum of F46+F47.
        tick(1'b1, 1'b0, 32'd0);
        fa = 32'd0;
        fb = 32'd1;
        for (int i = 0; i < 48; i++) begin
            tick(1'b0, 1'b1, fa);
            fn = fa + fb;
            fa = fb;
            fb = fn;
        end
        check("preload last", 64'(fa), 64'(32'd512559680));
        check("preload term",    64'(h_term),    64'(48));
        check("preload match",   64'(h_match),   64'(48));
        check("preload wrapped", 64'(h_wrapped), 64'(0));
        tick(1'b0, 1'b1, 32'd512559680);
        check("wrap term",    64'(h_term),    64'(49));
        check("wrap match",   64'(h_match),   64'(49));
        check("wrap wrapped", 64'(h_wrapped), 64'(1));
        check("wrap error",   64'(h_error),   64'(0));
        check("sat term",     64'(s_term),    64'(7));
        check("sat match",    64'(s_match),   64'(7));
        check("sat error",    64'(s_error),   64'(0));

        // Asynchronous reset mid-cycle after five terms.
        tick(1'b1, 1'b0, 32'd0);
        tick(1'b0, 1'b1, 32'd0);
        tick(1'b0, 1'b1, 32'd1);
        tick(1'b0, 1'b1, 32'd1);
        tick(1'b0, 1'b1, 32'd2);
        tick(1'b0, 1'b1, 32'd3);
        check("pre-rst term", 64'(h_term), 64'(5));
        #2;
        rst = 1'b1;
        #1;
        check_h_reset("async rst");
        #1;
        rst = 1'b0;
        tick(1'b0, 1'b1, 32'd0);
        tick(1'b0, 1'b1, 32'd1);
        tick(1'b0, 1'b1, 32'd1);
        check("restart match", 64'(h_match), 64'(3));
        check("restart term",  64'(h_term),  64'(3));
        check("restart error", 64'(h_error), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fibonacci_checker.md
# fibonacci_checker

Stream checker sitting at the consuming end of the Fibonacci generator's output. It accepts one term per valid cycle, checks that the first two terms equal the seeds and every later term equals the sum of the previous two (modulo 2^WIDTH), and counts matched terms. On the first mismatch it latches a diagnostic record: index, expected value and actual value. It is used as a self-checking monitor in the generator testbench and as an on-chip integrity monitor.

## Interface
- WIDTH, 32, data width of a term
- CNT_W, 16, width of term/match counters
- SEED0, 0, expected term index 0
- SEED1, 1, expected term index 1
- HALT_ON_ERR, 1, when 1, in_ready drops after the first error until clear
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-high
- clear  input  1  synchronous restart; returns to expecting SEED0 and clears all status
- in_valid  input  1  in_data holds a term this cycle
- in_data  input  WIDTH  term value
- in_ready  output  1  checker accepts a term this cycle; a term is accepted when in_valid && in_ready
- term_count  output  CNT_W  number of terms accepted
- match_count  output  CNT_W  number of accepted terms that matched
- error  output  1  sticky; first mismatch seen
- err_index  output  CNT_W  index (0-based) of the first mismatching term
- err_expected  output  WIDTH  expected value at the first mismatch
- err_actual  output  WIDTH  received value at the first mismatch
- wrapped  output  1  sticky; an expected sum exceeded 2^WIDTH-1

## Operation
- Reset values: state=S_FIRST, in_ready=1, term_count=0, match_count=0, error=0, err_index=0, err_expected=0, err_actual=0, wrapped=0, internal prev1=prev2=0.
- States:
  - S_FIRST: expected value is SEED0. Accepting a term goes to S_SECOND.
  - S_SECOND: expected value is SEED1. Accepting a term goes to S_RUN.
  - S_RUN: expected value is (prev1+prev2) mod 2^WIDTH. Stays in S_RUN.
  - S_HALT: entered on the first error only when HALT_ON_ERR=1. in_ready=0, and no terms are accepted.
- History update: on every accepted term, prev2<=prev1 and prev1<=in_data. The received value is used, not the expected value, so a single corrupted term gives at most three mismatches.
- Counters: term_count increments on every accept. match_count increments on an accept whose in_data equals the expected value. Both saturate at 2^CNT_W-1.
- Error capture: on the first mismatch, error<=1 and err_index<=term_count (pre-increment value). err_expected and err_actual are latched at the same time. Later mismatches do not overwrite the record.
- Wrap detection: in S_RUN, the carry-out of the WIDTH+1-bit sum prev1+prev2 sets wrapped on accept. Checking continues modulo 2^WIDTH.
- clear: behaves like reset but synchronous and has priority over an accept in the same cycle. The term presented in that cycle is not counted.
- in_valid low means no state change.

## Timing
- in_ready is combinational from state only, with no path from in_valid.
- All status outputs are registered. Status reflecting an accepted term is visible the cycle after the accepting edge.
- Throughput is one term per cycle. Latency from accept to error/counters is 1 cycle.
- HALT_ON_ERR=1: in_ready falls in the cycle after the failing accept. The failing term itself is counted.
- rst asserted mid-stream clears everything immediately, without waiting for a clock edge. After deassert, the next accepted term is index 0.

## Test plan
- Reset, then feed 0,1,1,2,3,5,8,13 at one term per cycle -> term_count=8, match_count=8, error=0, wrapped=0.
- Feed 0,1,1,2,4 -> error=1, err_index=4, err_expected=3, err_actual=4, match_count=4, in_ready=0 the next cycle (HALT_ON_ERR=1).
- HALT_ON_ERR=0: feed 0,1,1,2,4,6,10 -> error latched at index 4 unchanged, term_count=7, match_count=6 (6 and 10 match sums of the received values).
- Preload by feeding F0..F47 (last term 2971215073), then feed 512559680 -> match, wrapped=1, term_count=49, error=0.
- Insert idle cycles (in_valid=0) between terms, and assert clear together with in_valid -> no counts in idle cycles; after clear, term_count=0, error=0, and the next term is checked against SEED0.
- Assert rst asynchronously between clock edges after 5 terms -> all outputs return to reset values before the next edge. Restart 0,1,1 -> match_count=3.
